// File: rtl/debug_console.sv
// rtl/debug_console.sv - board debug front end: button debounce, CPU step enable, register/page select
module debug_console #(
   parameter int NUM_BTN         = 4,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REG_IDX_W       = 5,
   parameter int PAGE_W          = 2,
   parameter int RUN_DIV         = 25000000
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_BTN-1:0]            btn_raw,
   input  logic                          mode_run,
   input  logic [128*(2**PAGE_W)-1:0]    page_data,
   output logic [NUM_BTN-1:0]            btn_level,
   output logic [NUM_BTN-1:0]            btn_edge,
   output logic                          cpu_clk_en,
   output logic [REG_IDX_W-1:0]          reg_idx,
   output logic [PAGE_W-1:0]             page,
   output logic [127:0]                  disp_num,
   output logic                          disp_update
);

   localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
   localparam int DIV_W = $clog2(RUN_DIV);
   localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

   logic [NUM_BTN-1:0] btn_s1;
   logic [NUM_BTN-1:0] btn_s2;
   logic [NUM_BTN-1:0] level_d;
   logic [DB_W-1:0]    db_cnt [NUM_BTN];
   logic               mode_s1;
   logic               mode_s2;
   logic [DIV_W-1:0]   div_cnt;
   logic               primed;
   logic [127:0]       page_slice;

   always_ff @(posedge clk) begin
      if (reset) begin
         btn_s1    <= '0;
         btn_s2    <= '0;
         btn_level <= '0;
         level_d   <= '0;
         btn_edge  <= '0;
         for (int i = 0; i < NUM_BTN; i++) db_cnt[i] <= '0;
      end else begin
         btn_s1   <= btn_raw;
         btn_s2   <= btn_s1;
         level_d  <= btn_level;
         btn_edge <= btn_level & ~level_d;
         // any sample agreeing with the accepted level restarts the window
         for (int i = 0; i < NUM_BTN; i++) begin
            if (btn_s2[i] == btn_level[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_LAST) begin
               db_cnt[i]    <= '0;
               btn_level[i] <= ~btn_level[i];
            end else begin
               db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

   // a mode change is caught one stage early so the divider restarts in step with the synced mode
   always_ff @(posedge clk) begin
      if (reset) begin
         mode_s1    <= 1'b0;
         mode_s2    <= 1'b0;
         div_cnt    <= '0;
         cpu_clk_en <= 1'b0;
      end else begin
         mode_s1 <= mode_run;
         mode_s2 <= mode_s1;
         if (mode_s1 != mode_s2) begin
            div_cnt    <= '0;
            cpu_clk_en <= 1'b0;
         end else if (mode_s2) begin
            if (div_cnt == DIV_LAST) begin
               div_cnt    <= '0;
               cpu_clk_en <= 1'b1;
            end else begin
               div_cnt    <= div_cnt + DIV_W'(1);
               cpu_clk_en <= 1'b0;
            end
         end else begin
            div_cnt    <= '0;
            cpu_clk_en <= btn_edge[0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         reg_idx <= '0;
         page    <= '0;
      end else begin
         if (btn_edge[1] && !btn_edge[2]) begin
            reg_idx <= reg_idx + REG_IDX_W'(1);
         end else if (btn_edge[2] && !btn_edge[1]) begin
            reg_idx <= reg_idx - REG_IDX_W'(1);
         end
         if (btn_edge[3]) page <= page + PAGE_W'(1);
      end
   end

   assign page_slice = page_data[{page, 7'd0} +: 128];

   // primed masks the strobe for the load that follows reset release
   always_ff @(posedge clk) begin
      if (reset) begin
         disp_num    <= '0;
         disp_update <= 1'b0;
         primed      <= 1'b0;
      end else begin
         primed      <= 1'b1;
         disp_num    <= page_slice;
         disp_update <= primed && (page_slice != disp_num);
      end
   end

endmodule

// File: tb/tb_debug_console.sv
// tb/tb_debug_console.sv - scoreboard bench for debug_console
module tb_debug_console;

   localparam int NB = 4;
   localparam int RW = 5;
   localparam int PW = 2;

   typedef struct {
      int           cyc;
      logic [127:0] val;
   } ev_t;

   logic           clk = 1'b0;
   logic           reset = 1'b1;
   logic [NB-1:0]  btn_raw = '0;
   logic           mode_run = 1'b0;
   logic [511:0]   page_data = '0;
   logic [NB-1:0]  btn_level;
   logic [NB-1:0]  btn_edge;
   logic           cpu_clk_en;
   logic [RW-1:0]  reg_idx;
   logic [PW-1:0]  page;
   logic [127:0]   disp_num;
   logic           disp_update;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   ev_t q_edge[$];
   ev_t q_step[$];
   ev_t q_reg[$];
   ev_t q_page[$];
   ev_t q_disp[$];
   string qn[5] = '{"btn_edge", "cpu_clk_en", "reg_idx", "page", "disp_update"};
   logic [RW-1:0] prev_reg;
   logic [PW-1:0] prev_page;

   debug_console #(
      .NUM_BTN(NB), .DEBOUNCE_CYCLES(4), .REG_IDX_W(RW), .PAGE_W(PW), .RUN_DIV(5)
   ) dut (
      .clk(clk), .reset(reset), .btn_raw(btn_raw), .mode_run(mode_run),
      .page_data(page_data), .btn_level(btn_level), .btn_edge(btn_edge),
      .cpu_clk_en(cpu_clk_en), .reg_idx(reg_idx), .page(page),
      .disp_num(disp_num), .disp_update(disp_update)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [127:0] page_val(input int p);
      logic [3:0] nib;
      nib = 4'(p);
      return {32{nib}};
   endfunction

   function automatic logic [511:0] pattern();
      logic [511:0] pd;
      for (int p = 0; p < 4; p++) pd[128*p +: 128] = page_val(p);
      return pd;
   endfunction

   task automatic push(input int k, input int c, input logic [127:0] v);
      ev_t e;
      e.cyc = c;
      e.val = v;
      case (k)
         0: q_edge.push_back(e);
         1: q_step.push_back(e);
         2: q_reg.push_back(e);
         3: q_page.push_back(e);
         4: q_disp.push_back(e);
         default: ;
      endcase
   endtask

   task automatic pop_q(input int k, output ev_t e, output bit have);
      have = 1'b0;
      e.cyc = 0;
      e.val = '0;
      case (k)
         0: if (q_edge.size() > 0) begin e = q_edge.pop_front(); have = 1'b1; end
         1: if (q_step.size() > 0) begin e = q_step.pop_front(); have = 1'b1; end
         2: if (q_reg.size() > 0) begin e = q_reg.pop_front(); have = 1'b1; end
         3: if (q_page.size() > 0) begin e = q_page.pop_front(); have = 1'b1; end
         4: if (q_disp.size() > 0) begin e = q_disp.pop_front(); have = 1'b1; end
         default: ;
      endcase
   endtask

   task automatic take(input int k, input logic [127:0] act);
      ev_t e;
      bit  have;
      pop_q(k, e, have);
      vectors++;
      if (!have) begin
         miscompares++;
         $display("FAIL %s: unexpected event value %0h at cycle %0d", qn[k], act, cyc);
      end else if (e.cyc != cyc || e.val !== act) begin
         miscompares++;
         $display("FAIL %s: got %0h at cycle %0d, expected %0h at cycle %0d",
                  qn[k], act, cyc, e.val, e.cyc);
      end
   endtask

   task automatic drain(input int limit);
      ev_t e;
      bit  have;
      for (int k = 0; k < 5; k++) begin
         pop_q(k, e, have);
         while (have) begin
            if (e.cyc < limit) begin
               vectors++;
               miscompares++;
               $display("FAIL %s: missing event %0h expected at cycle %0d", qn[k], e.val, e.cyc);
            end
            pop_q(k, e, have);
         end
      end
   endtask

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic reset_checks();
      chk("rst btn_level", 128'(btn_level), '0);
      chk("rst btn_edge", 128'(btn_edge), '0);
      chk("rst cpu_clk_en", 128'(cpu_clk_en), '0);
      chk("rst reg_idx", 128'(reg_idx), '0);
      chk("rst page", 128'(page), '0);
      chk("rst disp_num", disp_num, '0);
      chk("rst disp_update", 128'(disp_update), '0);
   endtask

   task automatic do_reset(input int hold);
      reset = 1'b1;
      drain(cyc);
      tick(1);
      reset_checks();
      tick(hold - 1);
      reset = 1'b0;
   endtask

   always @(negedge clk) begin
      if (reset) begin
         prev_reg  = reg_idx;
         prev_page = page;
      end else begin
         for (int i = 0; i < NB; i++) if (btn_edge[i]) take(0, 128'(i));
         if (cpu_clk_en) take(1, 128'd1);
         if (reg_idx != prev_reg) take(2, 128'(reg_idx));
         if (page != prev_page) take(3, 128'(page));
         if (disp_update) take(4, disp_num);
         prev_reg  = reg_idx;
         prev_page = page;
      end
   end

   initial begin
      int c;
      int c0;
      page_data = pattern();
      tick(3);
      reset_checks();
      reset = 1'b0;
      tick(5);

      // single-step press held long
      btn_raw[0] = 1'b1;
      c = cyc;
      push(0, c + 7, 0);
      push(1, c + 8, 1);
      tick(14);
      btn_raw[0] = 1'b0;
      tick(10);

      // glitches one sample short of acceptance, then a restart-by-match pattern
      btn_raw[1] = 1'b1; tick(3);
      btn_raw[1] = 1'b0; tick(6);
      btn_raw[1] = 1'b1; tick(3);
      btn_raw[1] = 1'b0; tick(1);
      btn_raw[1] = 1'b1; tick(3);
      btn_raw[1] = 1'b0; tick(8);

      for (int k = 1; k <= 33; k++) begin
         btn_raw[1] = 1'b1;
         c = cyc;
         push(0, c + 7, 1);
         push(2, c + 8, 128'(k % 32));
         tick(8);
         btn_raw[1] = 1'b0;
         tick(8);
      end
      chk("reg_idx after 33 ups", 128'(reg_idx), 128'd1);

      // down wrap from reset, then simultaneous up/down
      do_reset(2);
      tick(3);
      btn_raw[2] = 1'b1;
      c = cyc;
      push(0, c + 7, 2);
      push(2, c + 8, 31);
      tick(8);
      btn_raw[2] = 1'b0;
      tick(8);
      btn_raw[2:1] = 2'b11;
      c = cyc;
      push(0, c + 7, 1);
      push(0, c + 7, 2);
      tick(8);
      btn_raw[2:1] = 2'b00;
      tick(8);
      chk("reg_idx after up+down", 128'(reg_idx), 128'd31);

      // free-run with a step press and a mode bounce that restarts the spacing
      mode_run = 1'b1;
      c0 = cyc;
      push(1, c0 + 7, 1);
      push(1, c0 + 12, 1);
      push(1, c0 + 17, 1);
      push(1, c0 + 22, 1);
      push(1, c0 + 33, 1);
      push(1, c0 + 38, 1);
      tick(3);
      btn_raw[0] = 1'b1;
      push(0, c0 + 10, 0);
      tick(12);
      btn_raw[0] = 1'b0;
      tick(9);
      mode_run = 1'b0;
      tick(2);
      mode_run = 1'b1;
      tick(13);
      mode_run = 1'b0;
      tick(15);

      // page walk with display follow
      for (int k = 1; k <= 4; k++) begin
         btn_raw[3] = 1'b1;
         c = cyc;
         push(0, c + 7, 3);
         push(3, c + 8, 128'(k % 4));
         push(4, c + 9, page_val(k % 4));
         tick(8);
         btn_raw[3] = 1'b0;
         tick(8);
      end
      page_data = {4{128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0}};
      c = cyc;
      push(4, c + 1, 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0);
      tick(3);
      btn_raw[3] = 1'b1;
      c = cyc;
      push(0, c + 7, 3);
      push(3, c + 8, 1);
      tick(8);
      btn_raw[3] = 1'b0;
      tick(8);
      chk("disp_num same data", disp_num, 128'hA5A5_5A5A_0F0F_F0F0_1234_5678_9ABC_DEF0);

      // reset in the middle of a debounce count and a free-run count
      page_data = pattern();
      c = cyc;
      push(4, c + 1, page_val(1));
      mode_run = 1'b1;
      tick(1);
      btn_raw[1] = 1'b1;
      tick(4);
      do_reset(2);
      c = cyc;
      push(0, c + 7, 1);
      push(2, c + 8, 1);
      push(1, c + 7, 1);
      push(1, c + 12, 1);
      tick(13);
      mode_run = 1'b0;
      tick(2);
      btn_raw[1] = 1'b0;
      tick(12);

      drain(32'h7fff_ffff);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
